// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reversal helper used by the FFT stages and reorder buffer.
package fft_pkg;

    localparam int unsigned N       = 64;
    localparam int unsigned LOG2N   = 6;
    localparam int unsigned DW      = 16;
    localparam int unsigned BR_MAXW = 16;
    localparam int unsigned BR_IW   = $clog2(BR_MAXW);

    // Reverse the low w bits of x; bits at and above w come back as zero.
    function automatic logic [BR_MAXW-1:0] bitrev(input logic [BR_MAXW-1:0] x,
                                                  input int unsigned       w);
        logic [BR_MAXW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BR_MAXW; i++) begin
            if (i < w) begin
                r[BR_IW'(i)] = x[BR_IW'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dp_ram_2n.sv
// Ping-pong sample store: 2N words, one write port and one registered read port (bank = address MSB).
module dp_ram_2n
    import fft_pkg::*;
#(
    parameter int unsigned N  = fft_pkg::N,
    parameter int unsigned DW = fft_pkg::DW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(N):0]      waddr,
    input  logic [2*DW-1:0]         wdata,
    input  logic                    re,
    input  logic [$clog2(N):0]      raddr,
    output logic [2*DW-1:0]         rdata
);

    logic [2*DW-1:0] mem [2*N];

    // Array contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed FFT output frames to natural order through a ping-pong buffer.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N  = fft_pkg::N,
    parameter int unsigned DW = fft_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 err_sop
);

    localparam int unsigned   AW   = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic {IDLE, READ} rd_state_t;

    rd_state_t     state, state_nxt;
    logic [AW-1:0] wr_cnt;
    logic          wr_bank;
    logic [1:0]    full;
    logic [AW-1:0] rd_cnt;
    logic          rd_bank;

    logic [AW-1:0] wr_idx_c;
    logic          wr_last_c;
    logic          rd_en_c;
    logic          rd_done_c;
    logic [AW:0]   waddr_c;
    logic [AW:0]   raddr_c;
    logic [2*DW-1:0] rdata;

    // A qualified sop restarts the frame at index 0 regardless of the current count.
    assign wr_idx_c  = (in_valid && in_sop) ? '0 : wr_cnt;
    assign wr_last_c = in_valid && (wr_idx_c == LAST);
    assign waddr_c   = {wr_bank, AW'(bitrev(BR_MAXW'(wr_idx_c), AW))};
    assign raddr_c   = {rd_bank, rd_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            err_sop <= 1'b0;
        end else if (in_valid) begin
            if (in_sop && (wr_cnt != '0)) begin
                err_sop <= 1'b1;
            end
            if (wr_last_c) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt  <= wr_idx_c + AW'(1);
            end
        end
    end

    // Set and clear always target different banks, so both may happen on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (wr_last_c) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_done_c) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en_c   = 1'b0;
        rd_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en_c = 1'b1;
                if (rd_cnt == LAST) begin
                    rd_done_c = 1'b1;
                    if (!full[~rd_bank]) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            if (rd_en_c) begin
                rd_cnt <= rd_done_c ? '0 : rd_cnt + AW'(1);
            end
            if (rd_done_c) begin
                rd_bank <= ~rd_bank;
            end
            out_valid <= rd_en_c;
            out_sop   <= rd_en_c && (rd_cnt == '0);
            out_eop   <= rd_done_c;
        end
    end

    dp_ram_2n #(
        .N  (N),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (in_valid),
        .waddr (waddr_c),
        .wdata ({in_re, in_im}),
        .re    (rd_en_c),
        .raddr (raddr_c),
        .rdata (rdata)
    );

    assign out_re = rdata[2*DW-1:DW];
    assign out_im = rdata[DW-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reverse reorder buffer: latency, ordering, gaps, resync and reset.
module tb_fft_bitrev_reorder;

    localparam int NS = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_sop = 1'b0;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               out_valid, out_sop, out_eop, err_sop;
    logic signed [15:0] out_re, out_im;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] q_re[$];
    logic [15:0] q_im[$];
    logic        q_sop[$];
    logic        q_eop[$];
    int          q_cyc[$];

    fft_bitrev_reorder #(.N(NS), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_re    (out_re),
        .out_im    (out_im),
        .err_sop   (err_sop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_re.push_back(out_re);
            q_im.push_back(out_im);
            q_sop.push_back(out_sop);
            q_eop.push_back(out_eop);
            q_cyc.push_back(cyc);
        end
    end

    function automatic int br6(input int x);
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            if (((x >> i) & 1) != 0) r = r | (1 << (5 - i));
        end
        return r;
    endfunction

    task automatic clear_q();
        q_re.delete(); q_im.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete();
    endtask

    task automatic feed(input int base, input int count, input bit gaps, output int last_edge);
        last_edge = 0;
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_sop    = (k == 0);
            in_re     = 16'(base + k);
            in_im     = 16'(-(base + k));
            last_edge = cyc + 1;
            if (gaps) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sop   = 1'b0;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic check_frame(input string name, input int start, input int base, input int first_cyc);
        logic [15:0] exp_re, exp_im;
        for (int j = 0; j < NS; j++) begin
            exp_re = 16'(base + br6(j));
            exp_im = 16'(-(base + br6(j)));
            vectors++;
            if (start + j >= q_re.size()) begin
                miscompares++;
                $display("FAIL %s sample %0d: missing, got %0d samples", name, j, q_re.size());
            end else begin
                if ({q_re[start+j], q_im[start+j]} !== {exp_re, exp_im}) begin
                    miscompares++;
                    $display("FAIL %s data[%0d]: got re=%0d im=%0d, want re=%0d im=%0d", name, j,
                             $signed(q_re[start+j]), $signed(q_im[start+j]), $signed(exp_re), $signed(exp_im));
                end
                vectors++;
                if ({q_sop[start+j], q_eop[start+j]} !== {(j == 0), (j == NS - 1)} ||
                    q_cyc[start+j] != first_cyc + j) begin
                    miscompares++;
                    $display("FAIL %s timing[%0d]: got sop=%b eop=%b cyc=%0d, want sop=%b eop=%b cyc=%0d",
                             name, j, q_sop[start+j], q_eop[start+j], q_cyc[start+j],
                             (j == 0), (j == NS - 1), first_cyc + j);
                end
            end
        end
    endtask

    task automatic check_count(input string name, input int want);
        vectors++;
        if (q_re.size() != want) begin
            miscompares++;
            $display("FAIL %s count: got %0d samples, want %0d", name, q_re.size(), want);
        end
    endtask

    task automatic check_err(input string name, input logic want);
        vectors++;
        if (err_sop !== want) begin
            miscompares++;
            $display("FAIL %s err_sop: got %b, want %b", name, err_sop, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, out_sop, out_eop, err_sop, out_re, out_im} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset outputs: got v=%b s=%b e=%b err=%b re=%0d im=%0d, want all 0",
                     out_valid, out_sop, out_eop, err_sop, out_re, out_im);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, out_sop, out_eop, err_sop} !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset flags: got %b, want 0000", {out_valid, out_sop, out_eop, err_sop});
        end
    endtask

    task automatic test_contiguous();
        int last;
        clear_q();
        feed(0, NS, 1'b0, last);
        go_idle();
        repeat (NS + 10) @(negedge clk);
        check_count("contig", NS);
        check_frame("contig", 0, 0, last + 2);
        check_err("contig", 1'b0);
    endtask

    task automatic test_gaps();
        int last;
        clear_q();
        feed(0, NS, 1'b1, last);
        go_idle();
        repeat (NS + 10) @(negedge clk);
        check_count("gaps", NS);
        check_frame("gaps", 0, 0, last + 2);
    endtask

    task automatic test_back_to_back();
        int last1, last2;
        clear_q();
        feed(0, NS, 1'b0, last1);
        feed(100, NS, 1'b0, last2);
        go_idle();
        repeat (NS + 10) @(negedge clk);
        check_count("b2b", 2 * NS);
        check_frame("b2b_f0", 0, 0, last1 + 2);
        check_frame("b2b_f1", NS, 100, last2 + 2);
    endtask

    task automatic test_resync();
        int last;
        clear_q();
        check_err("resync_pre", 1'b0);
        feed(500, 10, 1'b0, last);
        feed(0, NS, 1'b0, last);
        go_idle();
        repeat (NS + 10) @(negedge clk);
        check_count("resync", NS);
        check_frame("resync", 0, 0, last + 2);
        check_err("resync", 1'b1);
        repeat (20) @(negedge clk);
        check_err("resync_sticky", 1'b1);
    endtask

    task automatic test_reset_mid();
        int last;
        int waited;
        clear_q();
        feed(0, NS, 1'b0, last);
        go_idle();
        waited = 0;
        while (q_re.size() < 10 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (q_re.size() < 10) begin
            miscompares++;
            $display("FAIL reset_mid wait: got %0d samples after %0d cycles, want >= 10", q_re.size(), waited);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({out_valid, out_sop, out_eop} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid flags: got %b, want 000", {out_valid, out_sop, out_eop});
        end
        check_err("reset_mid", 1'b0);
        clear_q();
        repeat (NS + 40) @(negedge clk);
        check_count("reset_mid_quiet", 0);
        clear_q();
        feed(200, NS, 1'b0, last);
        go_idle();
        repeat (NS + 10) @(negedge clk);
        check_count("reset_mid_new", NS);
        check_frame("reset_mid_new", 0, 200, last + 2);
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter N, default 64: frame length in samples (power of 2).
REQ-002 SHALL have parameter DW, default 16: signed width of each real/imag component.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: input sample present this cycle.
REQ-006 SHALL have port in_sop, input, 1: first sample of a frame, qualified by in_valid.
REQ-007 SHALL have port in_re, input, DW: signed real part, bit-reversed FFT order.
REQ-008 SHALL have port in_im, input, DW: signed imaginary part.
REQ-009 SHALL have port out_valid, output, 1: output sample present.
REQ-010 SHALL have port out_sop, output, 1: natural index 0 of a frame.
REQ-011 SHALL have port out_eop, output, 1: natural index N-1 of a frame.
REQ-012 SHALL have port out_re, output, DW: signed real part, natural order.
REQ-013 SHALL have port out_im, output, DW: signed imaginary part.
REQ-014 SHALL have port err_sop, output, 1: sticky flag for a frame resync.

Function
REQ-015 SHALL store {in_re,in_im} at write address bitrev(wr_cnt) in the current write bank on each cycle with in_valid=1; wr_cnt SHALL be log2(N) bits.
REQ-016 SHALL tolerate arbitrary gaps in in_valid; wr_cnt SHALL hold while in_valid=0.
REQ-017 SHALL, on the accepted sample with wr_cnt=N-1, mark the write bank full, toggle the write bank and wrap wr_cnt to 0.
REQ-018 SHALL force wr_cnt to 0 when in_valid=1 and in_sop=1; the sample is stored as index 0.
REQ-019 SHALL, when in_sop arrives with wr_cnt!=0, discard the partial frame and set err_sop until reset.
REQ-020 SHALL ignore in_sop when in_valid=0.
REQ-021 SHALL implement a read FSM with two states: IDLE and READ.
REQ-022 IDLE->READ SHALL occur on the edge after a bank becomes full; rd_cnt is set to 0 and the read bank is latched.
REQ-023 READ SHALL issue address rd_cnt every cycle with no stalls; READ->IDLE after rd_cnt=N-1, unless the other bank is already full, in which case the FSM stays in READ with rd_cnt=0 on the other bank.
REQ-024 SHALL use registered RAM reads.
REQ-025 Latency: if the last sample of a frame is accepted on edge T, out_valid/out_sop SHALL first assert after edge T+2, then stay high for exactly N consecutive cycles.
REQ-026 out_sop SHALL be high only with natural index 0; out_eop SHALL be high only with index N-1.
REQ-027 SHALL clear the bank-full flag when its read completes.
REQ-028 Overflow is impossible: one write per cycle max, one read per cycle fixed, and ping-pong banks.
REQ-029 out_re/out_im SHALL pass through unmodified; there is no arithmetic or width change.

Reset
REQ-030 While rst=1 at a clock edge, SHALL clear wr_cnt, rd_cnt, both full flags, write/read bank select to 0, FSM to IDLE, out_valid/out_sop/out_eop/err_sop to 0, and out_re/out_im to 0.
REQ-031 RAM contents SHALL NOT be reset; a frame in flight at reset SHALL be dropped and produce no output.

Structure
REQ-032 Package fft_pkg SHALL hold N, LOG2N, DW and a bitrev function shared with the FFT stages.
REQ-033 Storage SHALL be one sub-module, dp_ram_2n, of depth 2N and width 2*DW: one write port and one registered read port, with the bank select as the address MSB.

Verification
REQ-034 Reset, then feed 64 contiguous samples with re=k, im=-k, in_sop at k=0 -> out_re sequence 0,32,16,48,8,40,... (bitrev of the index), im equal to the negation, first out_valid two edges after the last input.
REQ-035 Feed the same frame with in_valid toggling 1/0 -> identical output sequence, starting two edges after the 64th accepted sample.
REQ-036 Feed two back-to-back frames (re=k, then re=100+k) -> 128 contiguous out_valid cycles, second frame starting at 100, out_sop on cycles 0 and 64.
REQ-037 Feed 10 samples, then in_sop with a full 64-sample frame -> only the full frame is output, and err_sop=1 stays high.
REQ-038 Assert rst for 1 cycle mid-output -> out_valid=0 on the next edge, no further output until a new full frame arrives, and err_sop=0.
